ibutterfly_pipe: RTL and testbench
==================================

IBUTTERFLY_PIPE -- requirements
Module: ibutterfly_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: data word width, signed two's complement.
REQ-002 SHALL have parameter TW_FRAC, default 30: twiddle fraction bits (Q2.30); 1.0 = 0x40000000.
REQ-003 SHALL have parameter SCALE, default 1: arithmetic right shift applied to both outputs per pass.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports a1, b1, input, DW each: real and imaginary parts of first operand X.
REQ-007 SHALL have ports a2, b2, input, DW each: real and imaginary parts of second operand Y.
REQ-008 SHALL have ports wr, wi, input, DW each: twiddle W, real and imaginary.
REQ-009 SHALL have port in_valid, input, 1 bit: operand set presented.
REQ-010 SHALL have port in_ready, output, 1 bit: operand set accepted when in_valid and in_ready are both high.
REQ-011 SHALL have ports z1r, z1i, z2r, z2i, output, DW each: result pair.
REQ-012 SHALL have port out_valid, output, 1 bit: results valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts results.

Function
REQ-014 SHALL compute the inverse DIF butterfly: Z1 = (X+Y)>>>SCALE and Z2 = ((X-Y)*conj(W))>>>SCALE.
REQ-015 SHALL form stage 1 on DW+1 bits without overflow: sr=a1+a2, si=b1+b2, dr=a1-a2, di=b1-b2.
REQ-016 SHALL form stage 2 as four full-width signed products: p1=dr*wr, p2=di*wi, p3=di*wr, p4=dr*wi; sr and si are delayed alongside.
REQ-017 SHALL form stage 3 as z2r=(p1+p2)>>>(TW_FRAC+SCALE), z2i=(p3-p4)>>>(TW_FRAC+SCALE), z1r=sr>>>SCALE, z1i=si>>>SCALE.
REQ-018 SHALL round shifts toward negative infinity (floor); outputs SHALL take the low DW bits (wrap, no saturation).
REQ-019 SHALL be a 3-stage pipeline with a valid bit per stage; latency from accept to out_valid SHALL be exactly 3 cycles when not stalled.
REQ-020 SHALL use a global advance signal: adv = !out_valid | out_ready, and in_ready SHALL equal adv combinationally.
REQ-021 SHALL, when adv=1, shift all stages forward each cycle; stage-1 valid SHALL load in_valid.
REQ-022 SHALL, when adv=0, hold all stage registers and valids, and z*/out_valid SHALL remain stable.
REQ-023 SHALL pass bubbles through as invalid stages without compression.
REQ-024 SHALL sustain one result per cycle with in_valid=1 and out_ready=1 held.
REQ-025 SHALL ignore the data inputs when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL clear all stage valid bits and out_valid to 0 and all z* outputs to 0 while rst_n=0, independent of clk.
REQ-027 SHALL discard in-flight operands on reset mid-operation; the first out_valid after release SHALL come from a post-reset accept.
REQ-028 SHALL drive in_ready=1 during and after reset, since out_valid=0.

Verification
REQ-029 SHALL pass: W=1 (wr=0x40000000, wi=0), a1=100, a2=20, b1=b2=0 -> 3 cycles later z1r=60, z1i=0, z2r=40, z2i=0.
REQ-030 SHALL pass: W=j (wr=0, wi=0x40000000), a1=30, a2=20, b1=b2=0 -> z1r=25, z2r=0, z2i=-5.
REQ-031 SHALL pass floor check with W=1: a1=3, a2=0 -> z1r=1, z2r=1; a1=-3, a2=0 -> z1r=-2, z2r=-2.
REQ-032 SHALL pass stall check: out_ready=0 with 5 back-to-back inputs -> exactly 3 accepted, in_ready=0 afterward, outputs frozen; out_ready=1 -> results emerge in order, one per cycle.
REQ-033 SHALL pass streaming check: 16 random vectors at in_valid=out_ready=1 -> 16 results matching a reference model, in order, no gaps after the first 3 cycles.
REQ-034 SHALL pass reset check: rst_n pulsed low with 2 operands in flight -> out_valid=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/ibutterfly_pipe.sv
// ibutterfly_pipe
// ---------------
// Three-stage pipelined inverse DIF radix-2 butterfly.
//
//   Z1 = (X + Y) >>> SCALE
//   Z2 = ((X - Y) * conj(W)) >>> SCALE
//
// X = a1 + j*b1, Y = a2 + j*b2, W = wr + j*wi (W in Q2.TW_FRAC).
// All right shifts are arithmetic, so they round toward negative infinity;
// the outputs are the low DW bits of the shifted results (wrap, no saturate).
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   a1, b1              : operand X (real, imag), signed DW bits
//   a2, b2              : operand Y (real, imag), signed DW bits
//   wr, wi              : twiddle W (real, imag), signed Q2.TW_FRAC
//   in_valid / in_ready : input handshake
//   z1r, z1i, z2r, z2i  : result pair, signed DW bits
//   out_valid/out_ready : output handshake
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer keeps valid (and data) up until that edge;
// ready may depend combinationally on the consumer's ready. The whole pipe
// moves as one unit: adv = !out_valid | out_ready. While adv is high every
// stage shifts forward (empty stages travel as bubbles, never compressed);
// while adv is low every stage, including the outputs, holds. in_ready is adv.
//
// Stage map
//   S1: sums/differences on DW+1 bits, twiddle delayed alongside
//   S2: four full-width products, sums delayed alongside
//   S3: product combination, floor shift, truncate to DW bits -> outputs

module ibutterfly_pipe #(
    parameter int DW      = 32,
    parameter int TW_FRAC = 30,
    parameter int SCALE   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    input  logic [DW-1:0] a2,
    input  logic [DW-1:0] b2,
    input  logic [DW-1:0] wr,
    input  logic [DW-1:0] wi,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] z1r,
    output logic [DW-1:0] z1i,
    output logic [DW-1:0] z2r,
    output logic [DW-1:0] z2i,
    output logic          out_valid,
    input  logic          out_ready
);

    // EW: width of a sum/difference of two DW-bit values (cannot overflow).
    // PW: width of an EW x DW signed product (exact).
    // SW: width of a sum/difference of two products (exact).
    // SH: total shift applied to the product path (drop Q fraction + scale).
    localparam int EW = DW + 1;
    localparam int PW = EW + DW;
    localparam int SW = PW + 1;
    localparam int SH = TW_FRAC + SCALE;

    // Exact signed multiply: both operands sign-extended to the product width.
    function automatic logic signed [PW-1:0] smul(
        input logic signed [EW-1:0] d,
        input logic signed [DW-1:0] w
    );
        return PW'(d) * PW'(w);
    endfunction

    // ------------------------------------------------------------------
    // Global advance
    // ------------------------------------------------------------------
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: X+Y and X-Y on EW bits, twiddle carried along
    // ------------------------------------------------------------------
    logic                 s1_valid;
    logic signed [EW-1:0] s1_sr;
    logic signed [EW-1:0] s1_si;
    logic signed [EW-1:0] s1_dr;
    logic signed [EW-1:0] s1_di;
    logic signed [DW-1:0] s1_wr;
    logic signed [DW-1:0] s1_wi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sr    <= '0;
            s1_si    <= '0;
            s1_dr    <= '0;
            s1_di    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            // Data registers only load on a real transfer; a bubble leaves
            // them untouched so idle inputs are fully ignored.
            if (in_valid) begin
                s1_sr <= EW'($signed(a1)) + EW'($signed(a2));
                s1_si <= EW'($signed(b1)) + EW'($signed(b2));
                s1_dr <= EW'($signed(a1)) - EW'($signed(a2));
                s1_di <= EW'($signed(b1)) - EW'($signed(b2));
                s1_wr <= $signed(wr);
                s1_wi <= $signed(wi);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: (X-Y) * conj(W) partial products, sums carried along
    //   real = dr*wr + di*wi, imag = di*wr - dr*wi
    // ------------------------------------------------------------------
    logic                 s2_valid;
    logic signed [PW-1:0] s2_p1;
    logic signed [PW-1:0] s2_p2;
    logic signed [PW-1:0] s2_p3;
    logic signed [PW-1:0] s2_p4;
    logic signed [EW-1:0] s2_sr;
    logic signed [EW-1:0] s2_si;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p1    <= '0;
            s2_p2    <= '0;
            s2_p3    <= '0;
            s2_p4    <= '0;
            s2_sr    <= '0;
            s2_si    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p1 <= smul(s1_dr, s1_wr);
                s2_p2 <= smul(s1_di, s1_wi);
                s2_p3 <= smul(s1_di, s1_wr);
                s2_p4 <= smul(s1_dr, s1_wi);
                s2_sr <= s1_sr;
                s2_si <= s1_si;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: combine, floor-shift, keep the low DW bits
    // ------------------------------------------------------------------
    // The combined products are formed on SW bits so the add/subtract is
    // exact before the shift; truncation to DW happens only at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z1r       <= '0;
            z1i       <= '0;
            z2r       <= '0;
            z2i       <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                z1r <= DW'(s2_sr >>> SCALE);
                z1i <= DW'(s2_si >>> SCALE);
                z2r <= DW'((SW'(s2_p1) + SW'(s2_p2)) >>> SH);
                z2i <= DW'((SW'(s2_p3) - SW'(s2_p4)) >>> SH);
            end
        end
    end

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Testbench for ibutterfly_pipe (default parameters DW=32, TW_FRAC=30, SCALE=1).

module tb_ibutterfly_pipe;

    localparam int DW      = 32;
    localparam int TW_FRAC = 30;
    localparam int SCALE   = 1;
    localparam int RW      = 4 * DW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] a1, b1, a2, b2, wr, wi;
    logic          in_valid, in_ready;
    logic [DW-1:0] z1r, z1i, z2r, z2i;
    logic          out_valid, out_ready;

    always #5 clk = ~clk;

    ibutterfly_pipe #(.DW(DW), .TW_FRAC(TW_FRAC), .SCALE(SCALE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a1        (a1),
        .b1        (b1),
        .a2        (a2),
        .b2        (b2),
        .wr        (wr),
        .wi        (wi),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z1r       (z1r),
        .z1i       (z1i),
        .z2r       (z2r),
        .z2i       (z2i),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: complex arithmetic on wide integers, then floor shift and wrap.
    function automatic logic [RW-1:0] model(
        input logic [DW-1:0] x1r, x1i, x2r, x2i, w_r, w_i
    );
        logic signed [DW-1:0]  xa1, xb1, xa2, xb2, xwr, xwi;
        logic signed [127:0]   re, im, s_r, s_i;
        logic [DW-1:0]         o1r, o1i, o2r, o2i;
        xa1 = x1r; xb1 = x1i; xa2 = x2r; xb2 = x2i; xwr = w_r; xwi = w_i;
        s_r = 128'(xa1) + 128'(xa2);
        s_i = 128'(xb1) + 128'(xb2);
        re  = (128'(xa1) - 128'(xa2)) * 128'(xwr) + (128'(xb1) - 128'(xb2)) * 128'(xwi);
        im  = (128'(xb1) - 128'(xb2)) * 128'(xwr) - (128'(xa1) - 128'(xa2)) * 128'(xwi);
        o1r = DW'(s_r >>> SCALE);
        o1i = DW'(s_i >>> SCALE);
        o2r = DW'(re >>> (TW_FRAC + SCALE));
        o2i = DW'(im >>> (TW_FRAC + SCALE));
        return {o1r, o1i, o2r, o2i};
    endfunction

    // Scoreboard: handshakes are observed at the falling edge, i.e. they
    // describe the transfer that happens at the following rising edge.
    logic [RW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("sb_underflow", 1, 0);
                else
                    check("sb_data", {z1r, z1i, z2r, z2i}, exp_q.pop_front());
                n_pop++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a1, b1, a2, b2, wr, wi));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic set_vec(input logic [DW-1:0] x1r, x1i, x2r, x2i, w_r, w_i);
        a1 = x1r; b1 = x1i; a2 = x2r; b2 = x2i; wr = w_r; wi = w_i;
    endtask

    task automatic set_rand();
        set_vec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One operand set into an idle pipe; checks latency and exact result.
    task automatic run_one(input string tag,
                           input logic [DW-1:0] x1r, x1i, x2r, x2i, w_r, w_i,
                           input logic [DW-1:0] e1r, e1i, e2r, e2i);
        int n;
        bit seen;
        set_vec(x1r, x1i, x2r, x2i, w_r, w_i);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                next_cycle();
                n++;
            end
        end
        check({tag, "_lat"}, RW'(n), RW'(3));
        check({tag, "_val"}, {z1r, z1i, z2r, z2i}, {e1r, e1i, e2r, e2i});
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n_acc;
        int pop0;
        bit acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_vec('0, '0, '0, '0, '0, '0);

        // Reset state
        #12;
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_in_ready", RW'(in_ready), RW'(1));
        check("rst_z", {z1r, z1i, z2r, z2i}, '0);
        #5 rst_n = 1'b1;
        next_cycle();
        check("post_rst_in_ready", RW'(in_ready), RW'(1));

        // Directed values
        run_one("w_one", 100, 0, 20, 0, 32'h4000_0000, 0, 60, 0, 40, 0);
        run_one("w_j", 30, 0, 20, 0, 0, 32'h4000_0000, 25, 0, 0, 32'hFFFF_FFFB);
        run_one("floor_pos", 3, 0, 0, 0, 32'h4000_0000, 0, 1, 0, 1, 0);
        run_one("floor_neg", 32'hFFFF_FFFD, 0, 0, 0, 32'h4000_0000, 0,
                32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 0);

        // Stall: five cycles of in_valid with out_ready low
        out_ready = 1'b0;
        n_acc     = 0;
        set_rand();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = in_ready;
            next_cycle();
            if (acc) begin
                n_acc++;
                set_rand();
            end
        end
        in_valid = 1'b0;
        check("stall_accepted", RW'(n_acc), RW'(3));
        check("stall_in_ready", RW'(in_ready), RW'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_valid", RW'(out_valid), RW'(1));
            if (exp_q.size() == 0) check("stall_head", 1, 0);
            else check("stall_head", {z1r, z1i, z2r, z2i}, exp_q[0]);
            set_rand();
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_drain_valid", RW'(out_valid), RW'(k < 3));
            next_cycle();
        end
        check("stall_q_empty", RW'(exp_q.size()), RW'(0));

        // Streaming: 16 vectors back to back
        pop0 = n_pop;
        for (int cyc = 0; cyc < 23; cyc++) begin
            in_valid = (cyc < 16);
            set_rand();
            @(negedge clk);
            check("stream_valid", RW'(out_valid), RW'(cyc >= 3 && cyc < 19));
            next_cycle();
        end
        in_valid = 1'b0;
        check("stream_count", RW'(n_pop - pop0), RW'(16));

        // Random traffic with random backpressure
        for (int cyc = 0; cyc < 80; cyc++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            set_rand();
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) next_cycle();
        check("random_drained", RW'(exp_q.size()), RW'(0));

        // Reset with operands in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            next_cycle();
        end
        in_valid = 1'b0;
        check("inflight_out_valid", RW'(out_valid), RW'(1));
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_out_valid", RW'(out_valid), RW'(0));
        check("async_rst_z", {z1r, z1i, z2r, z2i}, '0);
        check("async_rst_in_ready", RW'(in_ready), RW'(1));
        out_ready = 1'b1;
        #7 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale", RW'(out_valid), RW'(0));
            next_cycle();
        end
        run_one("post_rst", 32'hFFFF_FF38, 50, 8, 32'hFFFF_FFF6, 32'h4000_0000, 0,
                32'hFFFF_FFA0, 20, 32'hFFFF_FF98, 30);
        check("final_q_empty", RW'(exp_q.size()), RW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
